// File: rtl/cochlea_event_readout_if.sv
// Readout stream bus for cochlea_event_readout: one channel count per transfer.
// A word moves when rd_valid and rd_ready are both high.
interface cochlea_event_readout_if #(
  parameter int CNT_W = 8
);
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_data;
  logic [2:0]       rd_ch;
  logic             rd_last;

  modport master (
    output rd_valid, rd_data, rd_ch, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_ch, rd_last,
    output rd_ready
  );
endinterface

// File: rtl/cochlea_event_readout.sv
// Cochlear filter-bank back-end: syncs decisions, counts ones per window, streams counts.
// Define COCHLEA_CNT_SAT_EN to make the per-channel counters saturate instead of wrap.
module cochlea_event_readout #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIN_W-1:0]         win_len,
  input  logic [N_CH-1:0]          high_buf,
  input  logic [N_CH-1:0]          phi1b_dig,
  output logic [N_CH-1:0]          fb1,
  cochlea_event_readout_if.master  rd,
  output logic                     overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [WIN_W:0]   WIN_ONE  = 1;
  localparam logic [2:0]       LAST_IDX = 3'(N_CH - 1);

  state_t           state_q, state_d;
  logic [N_CH-1:0]  hb_s1, hb_s2, hb_r;
  logic [N_CH-1:0]  ph_s1, ph_s2, ph_h, ev;
  logic [CNT_W-1:0] cnt      [N_CH];
  logic [CNT_W-1:0] cnt_inc  [N_CH];
  logic [CNT_W-1:0] snap_buf [N_CH];
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W:0]   win_inc, win_eff;
  logic [2:0]       idx;
  logic             close, xfer;

  // The event is registered so high_buf is sampled with the same alignment as phi.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_s1 <= '0;
      hb_s2 <= '0;
      hb_r  <= '0;
      ph_s1 <= '0;
      ph_s2 <= '0;
      ph_h  <= '0;
      ev    <= '0;
    end else begin
      hb_s1 <= high_buf;
      hb_s2 <= hb_s1;
      hb_r  <= hb_s2;
      ph_s1 <= phi1b_dig;
      ph_s2 <= ph_s1;
      ph_h  <= ph_s2;
      ev    <= ph_s2 & ~ph_h;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb1 <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ev[i]) fb1[i] <= hb_r[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_inc[i] = cnt[i];
      if (ev[i] && hb_r[i]) begin
`ifdef COCHLEA_CNT_SAT_EN
        if (cnt[i] != '1) cnt_inc[i] = cnt[i] + CNT_ONE;
`else
        cnt_inc[i] = cnt[i] + CNT_ONE;
`endif
      end
    end
    win_inc = {1'b0, win_cnt} + WIN_ONE;
    win_eff = (win_len == '0) ? WIN_ONE : {1'b0, win_len};
    // Greater-or-equal so a shrunken win_len closes on the very next ev[0].
    close   = en && ev[0] && (win_inc >= win_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      win_cnt <= '0;
    end else if (!en || close) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      win_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_inc[i];
      if (ev[0]) win_cnt <= win_inc[WIN_W-1:0];
    end
  end

  assign xfer = (state_q == SEND) && rd.rd_ready;

  // Snapshots arriving while a readout is busy are dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) snap_buf[i] <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (!en) overrun <= 1'b0;
      else if (close && state_q == SEND) overrun <= 1'b1;
      if (close && state_q == IDLE) begin
        for (int i = 0; i < N_CH; i++) snap_buf[i] <= cnt_inc[i];
        idx <= '0;
      end else if (xfer) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rd.rd_valid = 1'b0;
    rd.rd_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (close) state_d = SEND;
      end
      SEND: begin
        rd.rd_valid = 1'b1;
        rd.rd_last  = (idx == LAST_IDX);
        if (xfer && idx == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd.rd_data = snap_buf[idx];
  assign rd.rd_ch   = idx;

endmodule
